operand_fetch: RTL and testbench
================================

# operand_fetch

Decode-stage operand reader and ID/EX pipeline register for the 5-stage MIPS core. It drives both read ports of the register file and resolves RAW hazards by bypassing from the EX, MEM and WB stages. It stalls one cycle on a load-use dependency. Resolved operands are registered into the ID/EX stage together with destination and control information.

## Interface

Parameters: none; widths come from `mips_cpu_pkg` (`word_t` = 32 b, `reg_enum` = 5 b).

Ports:
- `cpu_clk_50M`  in  1  core clock
- `cpu_rst_n`  in  1  reset; synchronous, active-low
- `id_valid`  in  1  decode stage holds a valid instruction
- `id_rs`, `id_rt`  in  reg_enum  source register numbers
- `id_rs_en`, `id_rt_en`  in  1  instruction uses rs / rt
- `id_wa`  in  reg_enum  destination register
- `id_we`  in  1  instruction writes `id_wa`
- `id_is_load`  in  1  instruction is a load
- `rfre1`, `rfre2`  out  1  regfile read enables
- `rfra1`, `rfra2`  out  reg_enum  regfile read addresses
- `rfrd1`, `rfrd2`  in  word_t  regfile read data (async)
- `ex_result`  in  word_t  combinational ALU result of the current EX instruction
- `mem_we`  in  1  MEM-stage instruction writes a register
- `mem_wa`  in  reg_enum  MEM-stage destination
- `mem_wd`  in  word_t  MEM-stage result, load data included
- `wb_we`  in  1  WB-stage write enable, same signal as regfile `rfwe`
- `wb_wa`  in  reg_enum  WB destination, same as `rfwa`
- `wb_wd`  in  word_t  WB data, same as `rfwd`
- `flush`  in  1  kill the instruction entering EX (branch or exception)
- `ex_hold`  in  1  EX cannot accept, for example a multi-cycle op busy
- `id_stall`  out  1  hold IF/ID this cycle
- `ex_valid`  out  1  ID/EX register holds a live instruction
- `ex_src1`, `ex_src2`  out  word_t  resolved operands
- `ex_wa`  out  reg_enum  EX destination
- `ex_we`  out  1  EX write enable
- `ex_is_load`  out  1  EX instruction is a load

## Operation

Register-file port drive:
- `rfre1 = id_valid & id_rs_en`, `rfra1 = id_rs`.
- `rfre2 = id_valid & id_rt_en`, `rfra2 = id_rt`.

Operand resolution is done per source, in strict priority order:
1. **EX:** match when `ex_valid & ex_we & !ex_is_load & ex_wa==src`. Take `ex_result`.
2. **MEM:** match when `mem_we & mem_wa==src`. Take `mem_wd`.
3. **WB:** match when `wb_we & wb_wa==src`. Take `wb_wd`. This path is required because the regfile write is synchronous and does not appear on the async read in the same cycle.
4. **Regfile:** otherwise take `rfrdN`.

Additional operand rules:
- If `src==REG_ZERO` or the source is not enabled, the operand is `ZERO` and no bypass is applied, even if a stage targets r0.

Load-use hazard:
- Condition: `load_use = id_valid & ex_valid & ex_is_load & ex_we & ex_wa!=REG_ZERO & ((id_rs_en & id_rs==ex_wa) | (id_rt_en & id_rt==ex_wa))`.
- `id_stall = load_use | ex_hold`.

ID/EX update at each clock edge, first matching rule wins:
1. Reset: all outputs cleared.
2. `flush`: bubble; `ex_valid=0`, `ex_we=0`, `ex_is_load=0`.
3. `ex_hold`: register retains its contents.
4. `load_use`: bubble inserted; decode holds, because `id_stall=1`.
5. Otherwise: load `id_valid`, the resolved operands, `id_wa`, `id_we & id_valid`, and `id_is_load & id_valid`.

Bubble behaviour:
- A bubble has `ex_we=0`, so it never matches a bypass.
- Operand fields of a bubble are don't-care but must be driven to `ZERO`.

## Timing

- Reset value of every output: `ex_valid=0`, `ex_we=0`, `ex_is_load=0`, `ex_wa=REG_ZERO`, `ex_src1=ex_src2=ZERO`, `id_stall=0` while in reset.
- `id_stall` stays 0 through reset even if the inputs would assert it.
- `rfre*`, `rfra*` and `id_stall` are combinational from the inputs and current state.
- `ex_*` outputs change only at the clock edge; latency from ID to EX is 1 cycle.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM, so the dependent instruction is satisfied via the MEM bypass.
- `flush` together with `ex_hold`: flush wins, and `ex_hold` does not preserve a killed instruction.
- `flush` together with `load_use`: a bubble is inserted. `id_stall` is still asserted, and the upstream flush logic discards IF/ID.
- Reset mid-stall: the next cycle starts empty and no stale bypass matches remain.

## Structure

- Add to `mips_cpu_pkg`:
  - `fwd_sel_e {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}`
  - `idex_t` packed struct containing `valid`, `src1`, `src2`, `wa`, `we`, `is_load`
- Sub-module `fwd_mux`: one operand's priority selection (source number and enable, three stage taps, regfile data → `word_t`, `fwd_sel_e`). It is instantiated twice.
- ID/EX state is one `idex_t` register.

## Test plan

1. **Reset:** hold `cpu_rst_n=0` for 2 cycles with `id_valid=1` → all `ex_*` outputs are 0 and `id_stall=0`.
2. **EX bypass:** `addu r3` in EX with `ex_result=32'h0000_0010`, and ID reads `rs=r3` while regfile r3 holds `32'hDEAD_BEEF` → next-cycle `ex_src1=32'h10`.
3. **Priority:** EX, MEM and WB all target r5 with `0x1`, `0x2`, `0x3` → `ex_src1=0x1`. With EX removed → `0x2`. With EX and MEM removed → `0x3`.
4. **Load-use:** `lw r4` in EX, ID uses `rt=r4` → `id_stall=1` for one cycle and a bubble enters EX (`ex_valid=0`). On the next cycle `mem_wd=0xCAFE` → `ex_src2=0xCAFE`.
5. **r0:** MEM writes r0 with `0xFFFF_FFFF` and ID reads r0 → `ex_src1=ZERO`. A `lw r0` in EX does not stall.
6. **Control collision:** `flush=1` together with `ex_hold=1` while `ex_valid=1` → `ex_valid=0` next cycle. `ex_hold` alone keeps all `ex_*` outputs unchanged for N cycles.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS core datapath.
// Provides the word / register-number types, the operand bypass selector
// and the ID/EX pipeline register layout used by operand_fetch.
package mips_cpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_enum;

  localparam word_t   ZERO     = 32'h0000_0000;
  localparam reg_enum REG_ZERO = 5'd0;

  // Where a resolved operand came from.
  typedef enum logic [1:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM,
    FWD_EX
  } fwd_sel_e;

  typedef struct packed {
    logic    valid;
    word_t   src1;
    word_t   src2;
    reg_enum wa;
    logic    we;
    logic    is_load;
  } idex_t;

endpackage

// File: rtl/operand_fetch_if.sv
// ID/EX output bundle: the live contents of the ID/EX pipeline register.
//   master : driven by operand_fetch
//   slave  : consumed by the EX stage (and the bench)
interface operand_fetch_if;
  import mips_cpu_pkg::*;

  logic    ex_valid;
  word_t   ex_src1;
  word_t   ex_src2;
  reg_enum ex_wa;
  logic    ex_we;
  logic    ex_is_load;

  modport master (output ex_valid, ex_src1, ex_src2, ex_wa, ex_we, ex_is_load);
  modport slave  (input  ex_valid, ex_src1, ex_src2, ex_wa, ex_we, ex_is_load);
endinterface

// File: rtl/operand_fetch_fwd_mux.sv
// fwd_mux: priority bypass selection for one source operand.
//   src/src_en           : source register and whether it is read
//   ex_fwd_en/ex_wa/...  : EX tap (enable already excludes loads and bubbles)
//   mem_* / wb_*         : MEM and WB write taps
//   rf_rd                : async regfile read data
//   opnd / sel           : resolved operand and the tap it came from
module fwd_mux
  import mips_cpu_pkg::*;
(
  input  reg_enum  src,
  input  logic     src_en,
  input  logic     ex_fwd_en,
  input  reg_enum  ex_wa,
  input  word_t    ex_result,
  input  logic     mem_we,
  input  reg_enum  mem_wa,
  input  word_t    mem_wd,
  input  logic     wb_we,
  input  reg_enum  wb_wa,
  input  word_t    wb_wd,
  input  word_t    rf_rd,
  output word_t    opnd,
  output fwd_sel_e sel
);

  always_comb begin
    opnd = rf_rd;
    sel  = FWD_RF;
    // r0 and unused sources never bypass, even if a stage targets r0.
    if (!src_en || src == REG_ZERO) begin
      opnd = ZERO;
      sel  = FWD_RF;
    end else if (ex_fwd_en && ex_wa == src) begin
      opnd = ex_result;
      sel  = FWD_EX;
    end else if (mem_we && mem_wa == src) begin
      opnd = mem_wd;
      sel  = FWD_MEM;
    end else if (wb_we && wb_wa == src) begin
      // Regfile write lands at the edge, so the async read is still stale.
      opnd = wb_wd;
      sel  = FWD_WB;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode-stage operand reader and ID/EX pipeline register.
// Drives both regfile read ports, bypasses EX/MEM/WB results, stalls one
// cycle on load-use, and registers resolved operands into ID/EX.
//   cpu_clk_50M, cpu_rst_n : clock, synchronous active-low reset
//   id_*                   : decode-stage instruction fields
//   rfre*/rfra*/rfrd*      : regfile read ports
//   ex_result, mem_*, wb_* : bypass taps
//   flush, ex_hold         : pipeline control
//   id_stall               : hold IF/ID
//   ex                     : ID/EX register contents
module operand_fetch
  import mips_cpu_pkg::*;
(
  input  logic    cpu_clk_50M,
  input  logic    cpu_rst_n,
  input  logic    id_valid,
  input  reg_enum id_rs,
  input  reg_enum id_rt,
  input  logic    id_rs_en,
  input  logic    id_rt_en,
  input  reg_enum id_wa,
  input  logic    id_we,
  input  logic    id_is_load,
  output logic    rfre1,
  output logic    rfre2,
  output reg_enum rfra1,
  output reg_enum rfra2,
  input  word_t   rfrd1,
  input  word_t   rfrd2,
  input  word_t   ex_result,
  input  logic    mem_we,
  input  reg_enum mem_wa,
  input  word_t   mem_wd,
  input  logic    wb_we,
  input  reg_enum wb_wa,
  input  word_t   wb_wd,
  input  logic    flush,
  input  logic    ex_hold,
  output logic    id_stall,
  operand_fetch_if.master ex
);

  idex_t    idex_q, idex_d;
  word_t    opnd1, opnd2;
  fwd_sel_e fwd_sel1, fwd_sel2;
  logic     ex_fwd_en;
  logic     load_use;

  assign rfre1 = id_valid & id_rs_en;
  assign rfra1 = id_rs;
  assign rfre2 = id_valid & id_rt_en;
  assign rfra2 = id_rt;

  // A load's EX result is an address, not the data; it must wait for MEM.
  assign ex_fwd_en = idex_q.valid & idex_q.we & ~idex_q.is_load;

  // Gating the enables with id_valid keeps bubble operands at ZERO.
  fwd_mux u_fwd1 (
    .src(id_rs), .src_en(rfre1),
    .ex_fwd_en(ex_fwd_en), .ex_wa(idex_q.wa), .ex_result(ex_result),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .rf_rd(rfrd1), .opnd(opnd1), .sel(fwd_sel1)
  );

  fwd_mux u_fwd2 (
    .src(id_rt), .src_en(rfre2),
    .ex_fwd_en(ex_fwd_en), .ex_wa(idex_q.wa), .ex_result(ex_result),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .rf_rd(rfrd2), .opnd(opnd2), .sel(fwd_sel2)
  );

  assign load_use = id_valid & idex_q.valid & idex_q.is_load & idex_q.we &
                    (idex_q.wa != REG_ZERO) &
                    ((id_rs_en & (id_rs == idex_q.wa)) |
                     (id_rt_en & (id_rt == idex_q.wa)));

  // Forced low in reset so stale or unknown state cannot leak a stall.
  assign id_stall = cpu_rst_n & (load_use | ex_hold);

  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = '0;
    end else if (ex_hold) begin
      idex_d = idex_q;
    end else if (load_use) begin
      idex_d = '0;
    end else begin
      idex_d.valid   = id_valid;
      idex_d.src1    = opnd1;
      idex_d.src2    = opnd2;
      idex_d.wa      = id_wa;
      idex_d.we      = id_we & id_valid;
      idex_d.is_load = id_is_load & id_valid;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) idex_q <= '0;
    else            idex_q <= idex_d;
  end

  assign ex.ex_valid   = idex_q.valid;
  assign ex.ex_src1    = idex_q.src1;
  assign ex.ex_src2    = idex_q.src2;
  assign ex.ex_wa      = idex_q.wa;
  assign ex.ex_we      = idex_q.we;
  assign ex.ex_is_load = idex_q.is_load;

  // An EX-stage load must never be selected as a bypass source.
  a_no_load_ex_fwd: assert property (@(posedge cpu_clk_50M) disable iff (!cpu_rst_n)
    !(idex_q.is_load && (fwd_sel1 == FWD_EX || fwd_sel2 == FWD_EX)));

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  import mips_cpu_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    id_valid, id_rs_en, id_rt_en, id_we, id_is_load;
  reg_enum id_rs, id_rt, id_wa;
  logic    rfre1, rfre2;
  reg_enum rfra1, rfra2;
  word_t   rfrd1, rfrd2, ex_result, mem_wd, wb_wd;
  logic    mem_we, wb_we, flush, ex_hold, id_stall;
  reg_enum mem_wa, wb_wa;

  operand_fetch_if u_if ();

  operand_fetch dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_en(id_rs_en), .id_rt_en(id_rt_en),
    .id_wa(id_wa), .id_we(id_we), .id_is_load(id_is_load),
    .rfre1(rfre1), .rfre2(rfre2), .rfra1(rfra1), .rfra2(rfra2),
    .rfrd1(rfrd1), .rfrd2(rfrd2), .ex_result(ex_result),
    .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .flush(flush), .ex_hold(ex_hold), .id_stall(id_stall),
    .ex(u_if)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_bad = 0;
  idex_t exp_q[$];
  string name_q[$];

  function automatic idex_t mk(input logic v, input word_t s1, input word_t s2,
                               input reg_enum wa, input logic we, input logic ld);
    idex_t r;
    r.valid = v; r.src1 = s1; r.src2 = s2; r.wa = wa; r.we = we; r.is_load = ld;
    return r;
  endfunction

  // Monitor: the ID/EX register is checked one edge after each vector.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        idex_t e, a;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = mk(u_if.ex_valid, u_if.ex_src1, u_if.ex_src2, u_if.ex_wa,
               u_if.ex_we, u_if.ex_is_load);
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got v=%0b s1=%h s2=%h wa=%0d we=%0b ld=%0b, want v=%0b s1=%h s2=%h wa=%0d we=%0b ld=%0b",
                   n, a.valid, a.src1, a.src2, a.wa, a.we, a.is_load,
                   e.valid, e.src1, e.src2, e.wa, e.we, e.is_load);
        end
      end
    end
  end

  task automatic clr();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_en = 0; id_rt_en = 0;
    id_wa = 0; id_we = 0; id_is_load = 0;
    rfrd1 = 0; rfrd2 = 0; ex_result = 0;
    mem_we = 0; mem_wa = 0; mem_wd = 0;
    wb_we = 0; wb_wa = 0; wb_wd = 0;
    flush = 0; ex_hold = 0;
  endtask

  // Inputs are already applied at the negedge; check combinational outputs,
  // queue the expected ID/EX contents, then advance one cycle.
  task automatic tick(input string nm, input idex_t exp, input logic exp_stall);
    logic    e_re1, e_re2;
    #1;
    n_vec++;
    if (id_stall !== exp_stall) begin
      n_bad++;
      $display("FAIL %s.id_stall: got %0b want %0b", nm, id_stall, exp_stall);
    end
    e_re1 = id_valid & id_rs_en;
    e_re2 = id_valid & id_rt_en;
    n_vec++;
    if (rfre1 !== e_re1 || rfre2 !== e_re2 || rfra1 !== id_rs || rfra2 !== id_rt) begin
      n_bad++;
      $display("FAIL %s.rfport: got re=%0b%0b ra=%0d/%0d want re=%0b%0b ra=%0d/%0d",
               nm, rfre1, rfre2, rfra1, rfra2, e_re1, e_re2, id_rs, id_rt);
    end
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic instr(input reg_enum rs, input logic rs_en, input reg_enum rt,
                       input logic rt_en, input reg_enum wa, input logic we,
                       input logic ld);
    id_valid = 1; id_rs = rs; id_rs_en = rs_en; id_rt = rt; id_rt_en = rt_en;
    id_wa = wa; id_we = we; id_is_load = ld;
  endtask

  initial begin
    clr();
    @(negedge clk);

    // Reset with live decode and ex_hold asserted: outputs stay clear.
    rst_n = 0; ex_hold = 1;
    instr(5'd3, 1, 5'd4, 1, 5'd3, 1, 0);
    tick("reset0", mk(0, 0, 0, 0, 0, 0), 0);
    tick("reset1", mk(0, 0, 0, 0, 0, 0), 0);

    // A: addu r3 <- r3 from regfile (nothing in flight).
    rst_n = 1; clr();
    instr(5'd3, 1, 5'd0, 0, 5'd3, 1, 0); rfrd1 = 32'h0000_1111;
    tick("rf_read", mk(1, 32'h1111, 0, 5'd3, 1, 0), 0);

    // B: EX bypass of r3 over stale regfile value.
    clr();
    instr(5'd3, 1, 5'd7, 1, 5'd8, 1, 0);
    rfrd1 = 32'hDEAD_BEEF; rfrd2 = 32'h77; ex_result = 32'h10;
    tick("ex_bypass", mk(1, 32'h10, 32'h77, 5'd8, 1, 0), 0);

    // C: instruction writing r5 enters EX.
    clr();
    instr(5'd1, 1, 5'd0, 0, 5'd5, 1, 0); rfrd1 = 32'h11;
    tick("load_r5", mk(1, 32'h11, 0, 5'd5, 1, 0), 0);

    // D/E/F: EX > MEM > WB priority on r5.
    clr();
    instr(5'd5, 1, 5'd0, 0, 5'd9, 0, 0);
    rfrd1 = 32'hDEAD; ex_result = 32'h1;
    mem_we = 1; mem_wa = 5'd5; mem_wd = 32'h2;
    wb_we = 1; wb_wa = 5'd5; wb_wd = 32'h3;
    tick("prio_ex", mk(1, 32'h1, 0, 5'd9, 0, 0), 0);
    tick("prio_mem", mk(1, 32'h2, 0, 5'd9, 0, 0), 0);
    mem_we = 0;
    instr(5'd5, 1, 5'd0, 0, 5'd4, 1, 1);   // lw r4
    tick("prio_wb", mk(1, 32'h3, 0, 5'd4, 1, 1), 0);

    // G: load-use on rt=r4 -> stall and bubble.
    clr();
    instr(5'd0, 0, 5'd4, 1, 5'd6, 1, 0);
    rfrd2 = 32'h5; ex_result = 32'h999;
    tick("lu_bubble", mk(0, 0, 0, 0, 0, 0), 1);
    // H: load now in MEM, satisfied by bypass.
    mem_we = 1; mem_wa = 5'd4; mem_wd = 32'hCAFE;
    tick("lu_mem", mk(1, 0, 32'hCAFE, 5'd6, 1, 0), 0);

    // I: r0 reads ignore MEM targeting r0; lw r0 enters EX.
    clr();
    instr(5'd0, 1, 5'd0, 0, 5'd0, 1, 1);
    rfrd1 = 32'h5555; mem_we = 1; mem_wa = 5'd0; mem_wd = 32'hFFFF_FFFF;
    tick("r0_read", mk(1, 0, 0, 5'd0, 1, 1), 0);
    // J: lw r0 in EX does not stall a reader of r0.
    clr();
    instr(5'd0, 0, 5'd0, 1, 5'd2, 1, 0); rfrd2 = 32'h1234;
    tick("r0_nostall", mk(1, 0, 0, 5'd2, 1, 0), 0);

    // K: flush + ex_hold with live EX -> bubble.
    flush = 1; ex_hold = 1;
    tick("flush_hold", mk(0, 0, 0, 0, 0, 0), 1);

    // L: load a fresh instruction, then hold it for 3 cycles.
    clr();
    instr(5'd1, 1, 5'd2, 1, 5'd7, 1, 0);
    rfrd1 = 32'hABCD; rfrd2 = 32'h4321;
    tick("pre_hold", mk(1, 32'hABCD, 32'h4321, 5'd7, 1, 0), 0);
    ex_hold = 1; rfrd1 = 32'hFFFF; rfrd2 = 32'hEEEE;
    for (int i = 0; i < 3; i++) begin
      id_wa = reg_enum'(i + 10);
      tick($sformatf("hold%0d", i), mk(1, 32'hABCD, 32'h4321, 5'd7, 1, 0), 1);
    end
    // N: flush alone.
    ex_hold = 0; flush = 1;
    tick("flush", mk(0, 0, 0, 0, 0, 0), 0);

    // O/P/Q: reset in the middle of a load-use stall.
    clr();
    instr(5'd0, 0, 5'd0, 0, 5'd4, 1, 1);
    tick("lw_r4", mk(1, 0, 0, 5'd4, 1, 1), 0);
    instr(5'd0, 0, 5'd4, 1, 5'd6, 1, 0); rfrd2 = 32'h4444;
    rst_n = 0;
    tick("rst_stall", mk(0, 0, 0, 0, 0, 0), 0);
    rst_n = 1;
    tick("post_rst", mk(1, 0, 32'h4444, 5'd6, 1, 0), 0);

    clr();
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end want end");
    $fatal(1, "timeout");
  end

endmodule
